// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush scheduler.
//   stall_t       per-stage hold vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   STALL_*       canned stall patterns for each stall source
//   div_state_e   divider sequencer states
//   *_DEFAULT     default parameter values for pipe_ctrl
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_t;

  localparam stall_t STALL_NONE    = 6'b000000;
  localparam stall_t STALL_LOADUSE = 6'b000111;  // PC/IF/ID hold, bubble into EX
  localparam stall_t STALL_DIV     = 6'b001111;  // EX holds the divide as well
  localparam stall_t STALL_MEM     = 6'b011111;  // everything up to MEM holds, bubble into WB

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [31:0] EXC_ENTRY_DEFAULT  = 32'hBFC0_0380;
  localparam int          DIV_CYCLES_DEFAULT = 33;

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// div_seq: occupancy sequencer for the multi-cycle divider sitting in EX.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// DIV_IDLE | no divide in flight; a start requests a stall combinationally
// DIV_BUSY | divider running; counter walks down to the terminal count
// DIV_DONE | result valid for one cycle (longer while hold is high)
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      EX holds a DIV/DIVU (ignored outside IDLE)
//   abort      flush: return to IDLE next cycle, suppress done
//   hold       keep DONE asserted (memory stall in progress)
//   busy       FSM is in BUSY
//   done       result-valid pulse
//   stall_req  divide stall request toward the priority mux
module div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic hold,
  output logic busy,
  output logic done,
  output logic stall_req
);

  // The start cycle is already a stall cycle, so BUSY lasts DIV_CYCLES-2 cycles.
  localparam int              CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DIV_CYCLES - 2);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_cnt_dec = r_cnt - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    done        = 1'b0;
    stall_req   = 1'b0;

    unique case (r_state)
      DIV_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          w_cnt_nxt = LOAD;
          // With DIV_CYCLES==2 the start cycle is the whole stall span.
          w_state_nxt = (LOAD == '0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        busy      = 1'b1;
        stall_req = 1'b1;
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          w_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done = 1'b1;
        if (!hold) begin
          w_state_nxt = DIV_IDLE;
        end
      end
      default: begin
        w_state_nxt = DIV_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A flush kills the divide outright; its result must never be reported.
    if (abort) begin
      w_state_nxt = DIV_IDLE;
      w_cnt_nxt   = '0;
      done        = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Merges load-use hazards, divider occupancy and MEM-stage exceptions/ERET
// into one stall vector, a flush pulse and a redirect PC.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_reg1_read_i/id_rs_i    ID reads rs / its address
//   id_reg2_read_i/id_rt_i    ID reads rt / its address
//   ex_rmem_i, ex_wreg_i      EX is a load / writes the regfile
//   ex_wd_i                   EX destination register
//   ex_div_start_i            EX holds DIV/DIVU
//   mem_exception_i           exception taken in MEM
//   mem_is_eret_i             MEM holds ERET (redirect to EPC)
//   cp0_epc_i                 current EPC
//   mem_stall_req_i           data-memory wait (only with PIPE_CTRL_MEM_STALL_EN)
//   stall_o                   per-stage hold vector
//   flush_o, new_pc_o         flush pulse and redirect target
//   div_busy_o, div_done_o    divider status
//
// Build option: define PIPE_CTRL_MEM_STALL_EN to add the memory stall path.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        ex_rmem_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_div_start_i,
  input  logic        mem_exception_i,
  input  logic        mem_is_eret_i,
  input  logic [31:0] cp0_epc_i,
`ifdef PIPE_CTRL_MEM_STALL_EN
  input  logic        mem_stall_req_i,
`endif
  output stall_t      stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        div_busy_o,
  output logic        div_done_o
);

  logic w_flush;
  logic w_mem_stall;
  logic w_load_use;
  logic w_div_busy;
  logic w_div_done;
  logic w_div_stall;

  assign w_flush = mem_exception_i | mem_is_eret_i;

`ifdef PIPE_CTRL_MEM_STALL_EN
  assign w_mem_stall = mem_stall_req_i;
`else
  assign w_mem_stall = 1'b0;
`endif

  // $0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign w_load_use = ex_rmem_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                      ((id_reg1_read_i & (id_rs_i == ex_wd_i)) |
                       (id_reg2_read_i & (id_rt_i == ex_wd_i)));

  div_seq #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_div_start_i),
    .abort     (w_flush),
    .hold      (w_mem_stall),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .stall_req (w_div_stall)
  );

  always_comb begin
    stall_o    = STALL_NONE;
    flush_o    = 1'b0;
    new_pc_o   = 32'h0;
    div_busy_o = 1'b0;
    div_done_o = 1'b0;

    // Outputs stay quiet while reset is asserted, whatever the inputs do.
    if (!rst) begin
      div_busy_o = w_div_busy;
      div_done_o = w_div_done;
      if (w_flush) begin
        flush_o  = 1'b1;
        new_pc_o = mem_is_eret_i ? cp0_epc_i : EXC_ENTRY;
      end else if (w_mem_stall) begin
        stall_o = STALL_MEM;
      end else if (w_div_stall) begin
        stall_o = STALL_DIV;
      end else if (w_load_use) begin
        stall_o = STALL_LOADUSE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_read_i, id_reg2_read_i;
  logic [4:0]  id_rs_i, id_rt_i;
  logic        ex_rmem_i, ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_div_start_i;
  logic        mem_exception_i, mem_is_eret_i;
  logic [31:0] cp0_epc_i;
  logic        mem_stall_req_i;
  stall_t      stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_busy_o, div_done_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(33), .EXC_ENTRY(32'hBFC0_0380)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read_i  (id_reg1_read_i),
    .id_reg2_read_i  (id_reg2_read_i),
    .id_rs_i         (id_rs_i),
    .id_rt_i         (id_rt_i),
    .ex_rmem_i       (ex_rmem_i),
    .ex_wreg_i       (ex_wreg_i),
    .ex_wd_i         (ex_wd_i),
    .ex_div_start_i  (ex_div_start_i),
    .mem_exception_i (mem_exception_i),
    .mem_is_eret_i   (mem_is_eret_i),
    .cp0_epc_i       (cp0_epc_i),
`ifdef PIPE_CTRL_MEM_STALL_EN
    .mem_stall_req_i (mem_stall_req_i),
`endif
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .div_busy_o      (div_busy_o),
    .div_done_o      (div_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input stall_t s, input logic f, input logic [31:0] pc,
                              input logic b, input logic d);
    exp_t e;
    e.stall = s; e.flush = f; e.pc = pc; e.busy = b; e.done = d;
    return e;
  endfunction

  // Inputs are already set by the caller; push the expectation, compare at negedge.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    chk({tag, ".stall"}, 32'(stall_o),    32'(got.stall));
    chk({tag, ".flush"}, 32'(flush_o),    32'(got.flush));
    chk({tag, ".pc"},    new_pc_o,        got.pc);
    chk({tag, ".busy"},  32'(div_busy_o), 32'(got.busy));
    chk({tag, ".done"},  32'(div_done_o), 32'(got.done));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_reg1_read_i = 0; id_reg2_read_i = 0; id_rs_i = 0; id_rt_i = 0;
    ex_rmem_i = 0; ex_wreg_i = 0; ex_wd_i = 0; ex_div_start_i = 0;
    mem_exception_i = 0; mem_is_eret_i = 0; cp0_epc_i = 0; mem_stall_req_i = 0;
  endtask

  task automatic set_lw_hazard();
    ex_rmem_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd2; id_reg1_read_i = 1; id_rs_i = 5'd2;
  endtask

  // One full divide: k=1 start cycle, k=2..32 BUSY, k=33 DONE.
  task automatic run_div(input string tag, input bit hold_start, input bit lu_mid);
    for (int k = 1; k <= 33; k++) begin
      ex_div_start_i = hold_start ? 1'b1 : (k == 1);
      if (lu_mid && k == 5) set_lw_hazard();
      if (lu_mid && k == 6) begin
        ex_rmem_i = 0; ex_wreg_i = 0; ex_wd_i = 0; id_reg1_read_i = 0; id_rs_i = 0;
      end
      step($sformatf("%s.k%0d", tag, k),
           mk((k <= 32) ? STALL_DIV : STALL_NONE, 1'b0, 32'h0,
              (k >= 2 && k <= 32), (k == 33)));
    end
    ex_div_start_i = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step("reset0", mk(STALL_NONE, 0, 0, 0, 0));
    step("reset1", mk(STALL_NONE, 0, 0, 0, 0));
    rst = 0;
    step("idle", mk(STALL_NONE, 0, 0, 0, 0));

    // Load-use hazards
    set_lw_hazard();
    step("lu_rs", mk(STALL_LOADUSE, 0, 0, 0, 0));
    id_reg1_read_i = 0; id_rs_i = 5'd5; id_reg2_read_i = 1; id_rt_i = 5'd2;
    step("lu_rt", mk(STALL_LOADUSE, 0, 0, 0, 0));
    id_reg2_read_i = 0;
    step("lu_noread", mk(STALL_NONE, 0, 0, 0, 0));
    ex_wd_i = 5'd0; id_reg1_read_i = 1; id_rs_i = 5'd0;
    step("lu_r0", mk(STALL_NONE, 0, 0, 0, 0));
    ex_wd_i = 5'd2; id_rs_i = 5'd2; ex_rmem_i = 0;
    step("lu_notload", mk(STALL_NONE, 0, 0, 0, 0));
    ex_rmem_i = 1; ex_wreg_i = 0;
    step("lu_nowreg", mk(STALL_NONE, 0, 0, 0, 0));
    clear_inputs();

    // Plain divide, then back-to-back, then start held through DONE
    run_div("div", 0, 0);
    step("div_after", mk(STALL_NONE, 0, 0, 0, 0));
    run_div("b2b_a", 0, 1);
    run_div("b2b_b", 0, 0);
    run_div("div_hold", 1, 0);
    step("div_hold_after", mk(STALL_NONE, 0, 0, 0, 0));

    // Flush in BUSY cycle 10
    for (int k = 1; k <= 10; k++) begin
      ex_div_start_i = (k == 1);
      step($sformatf("fl.k%0d", k), mk(STALL_DIV, 0, 0, (k >= 2), 0));
    end
    mem_exception_i = 1;
    step("fl.exc", mk(STALL_NONE, 1, 32'hBFC0_0380, 1, 0));
    mem_exception_i = 0;
    for (int k = 12; k <= 40; k++)
      step($sformatf("fl.post%0d", k), mk(STALL_NONE, 0, 0, 0, 0));

    // ERET, and ERET together with an exception
    mem_is_eret_i = 1; cp0_epc_i = 32'hBFC0_1234;
    step("eret", mk(STALL_NONE, 1, 32'hBFC0_1234, 0, 0));
    mem_exception_i = 1; cp0_epc_i = 32'h8000_0040;
    step("eret_exc", mk(STALL_NONE, 1, 32'h8000_0040, 0, 0));
    mem_is_eret_i = 0;
    set_lw_hazard();
    step("exc_over_lu", mk(STALL_NONE, 1, 32'hBFC0_0380, 0, 0));
    clear_inputs();
    step("post_flush", mk(STALL_NONE, 0, 0, 0, 0));

    // Reset in BUSY cycle 5
    for (int k = 1; k <= 5; k++) begin
      ex_div_start_i = (k == 1);
      step($sformatf("rs.k%0d", k), mk(STALL_DIV, 0, 0, (k >= 2), 0));
    end
    rst = 1;
    step("rs.assert", mk(STALL_NONE, 0, 0, 0, 0));
    rst = 0;
    step("rs.after", mk(STALL_NONE, 0, 0, 0, 0));
    run_div("rs.div", 0, 0);
    step("rs.div_after", mk(STALL_NONE, 0, 0, 0, 0));

`ifdef PIPE_CTRL_MEM_STALL_EN
    // Memory stall across DONE: counter keeps running, DONE held until release
    for (int k = 1; k <= 36; k++) begin
      ex_div_start_i  = (k == 1);
      mem_stall_req_i = (k == 20 || k == 33 || k == 34);
      if (k == 20 || k == 33 || k == 34)
        step($sformatf("ms.k%0d", k), mk(STALL_MEM, 0, 0, (k == 20), (k >= 33)));
      else if (k <= 32)
        step($sformatf("ms.k%0d", k), mk(STALL_DIV, 0, 0, (k >= 2), 0));
      else if (k == 35)
        step("ms.release", mk(STALL_NONE, 0, 0, 0, 1));
      else
        step("ms.idle", mk(STALL_NONE, 0, 0, 0, 0));
    end
    clear_inputs();
`endif

    if (sb_q.size() != 0) chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
